// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch stage that owns the PC, issues word fetches and queues {pc, instr} for decode.
// Latency: a memory response reaches if_valid one cycle later at the earliest (no empty-queue bypass).
// Backpressure: if_ready low fills the queue; issue stops once queued + in-flight words reach BUF_DEPTH.
//
// Ports:
//   clock, reset_n                  single clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request handshake; addr held stable until accepted
//   imem_rsp_valid/data             in-order responses, always accepted
//   redirect_valid/pc               taken branch/jump from execute; flushes and restarts fetch
//   if_valid/ready/instruction/pc   head of instruction queue to decode (NOP when !if_valid)
//   if_pc_plus4                     link value for JAL/JALR
// Optional: define IFETCH_MISALIGN_TRAP_EN to add if_misalign and a FAULT state for misaligned redirects.
module ifetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          BUF_DEPTH       = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic        if_misalign
`endif
);

   localparam int            PW    = $clog2(BUF_DEPTH);
   localparam int            CW    = $clog2(BUF_DEPTH + 1);
   localparam int            OW    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
   localparam logic [31:0]   NOP   = 32'h0000_0013;

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_FAULT} state_t;

   state_t          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [OW-1:0]   outst_q, outst_d;
   logic [OW-1:0]   drop_q, drop_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     qpc_q  [BUF_DEPTH];
   logic [31:0]     qdat_q [BUF_DEPTH];
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic [31:0]     fault_pc_q, fault_pc_d;
`endif

   logic            push, pop, req_fire;
   logic [OW-1:0]   outst_rsp;
   logic [31:0]     redir_pc_al;

   // Low address bits of a redirect never reach the PC; a word-aligned target is assumed.
   assign redir_pc_al = redirect_pc & 32'hFFFF_FFFC;

   // Every request reserves a queue slot, so a response can never find the queue full.
   // Gated by reset_n so no request is offered while the memory is itself in reset.
   // A same-cycle redirect withdraws the request so no stale fetch is issued.
   assign imem_req_valid = reset_n && (state_q == ST_RUN) && !redirect_valid &&
                           (outst_q < MAX_O) &&
                           ((32'(count_q) + 32'(outst_q)) < 32'(BUF_DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign if_valid = (count_q != '0);
   assign pop      = if_valid && if_ready && !redirect_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign if_misalign = (state_q == ST_FAULT);
`endif

   always_comb begin
      if_instruction = NOP;
      if_pc          = '0;
      if_pc_plus4    = '0;
      if (if_valid) begin
         if_instruction = qdat_q[rd_ptr_q];
         if_pc          = qpc_q[rd_ptr_q];
         if_pc_plus4    = qpc_q[rd_ptr_q] + 32'd4;
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      else if (state_q == ST_FAULT) begin
         if_pc       = fault_pc_q;
         if_pc_plus4 = fault_pc_q + 32'd4;
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      count_d    = count_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      push       = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fault_pc_d = fault_pc_q;
`endif
      outst_rsp  = (imem_rsp_valid && outst_q != '0) ? outst_q - OW'(1) : outst_q;

      if (redirect_valid) begin
         // Every request still in flight after this cycle belongs to the old path.
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = redir_pc_al;
         rsp_pc_d   = redir_pc_al;
         outst_d    = outst_rsp;
         drop_d     = outst_rsp;
         state_d    = (outst_rsp != '0) ? ST_FLUSH : ST_RUN;
`ifdef IFETCH_MISALIGN_TRAP_EN
         if (redirect_pc[1:0] != 2'b00) begin
            state_d    = ST_FAULT;
            fault_pc_d = redirect_pc;
         end
`endif
      end else begin
         outst_d = req_fire ? outst_rsp + OW'(1) : outst_rsp;
         push    = imem_rsp_valid && (drop_q == '0) && (state_q != ST_FAULT);
         if (imem_rsp_valid && drop_q != '0)
            drop_d = drop_q - OW'(1);
         if (req_fire)
            fetch_pc_d = fetch_pc_q + 32'd4;
         if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)
            count_d = count_q + CW'(1);
         else if (pop && !push)
            count_d = count_q - CW'(1);
         if (state_q == ST_FLUSH && drop_d == '0)
            state_d = ST_RUN;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         fault_pc_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
         fault_pc_q <= fault_pc_d;
`endif
      end
   end

   // Queue storage needs no reset: entries are only read while count_q says they are valid.
   always_ff @(posedge clock) begin
      if (push) begin
         qpc_q[wr_ptr_q]  <= rsp_pc_q;
         qdat_q[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed per-cycle vectors plus hand sequences for ifetch_queue.
// Latency: the bench memory answers each accepted request after 1 or 2 cycles, in order.
// Backpressure: the bench drives imem_req_ready and if_ready from the vectors.
module tb_ifetch_queue;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        if_misalign;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int lat    = 1;

   ifetch_queue dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instruction (if_instruction),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4)
`ifdef IFETCH_MISALIGN_TRAP_EN
      ,
      .if_misalign    (if_misalign)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[15:0]};
   endfunction

   // Instruction memory: fixed latency of 1 or 2 cycles, one response per accepted request.
   logic        s1_v, s2_v;
   logic [31:0] s1_a, s2_a;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s1_a <= '0; s2_a <= '0;
      end else begin
         s1_v <= imem_req_valid && imem_req_ready;
         s1_a <= imem_req_addr;
         s2_v <= s1_v;
         s2_a <= s1_a;
      end
   end
   assign imem_rsp_valid = (lat == 1) ? s1_v : s2_v;
   assign imem_rsp_data  = word((lat == 1) ? s1_a : s2_a);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic do_reset(input int l);
      reset_n        = 1'b0;
      if_ready       = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      lat            = l;
      @(negedge clock);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_instr", if_instruction, 32'h0000_0013);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
      chk("rst_if_misalign", 32'(if_misalign), 32'd0);
`endif
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      bit          rst;
      int          lt;
      bit          ifr;
      bit          mr;
      bit          rd;
      logic [31:0] rpc;
      bit          erv;
      logic [31:0] ea;
      bit          eiv;
      logic [31:0] ep;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit rst, int lt, bit ifr, bit mr, bit rd, logic [31:0] rpc,
                               bit erv, logic [31:0] ea, bit eiv, logic [31:0] ep);
      vec_t v;
      v.rst = rst; v.lt = lt; v.ifr = ifr; v.mr = mr; v.rd = rd; v.rpc = rpc;
      v.erv = erv; v.ea = ea; v.eiv = eiv; v.ep = ep;
      return v;
   endfunction

   initial begin
      reset_n        = 1'b1;
      if_ready       = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Streaming from reset, then if_ready low for 10 cycles, then drain.
      vecs.push_back(mk(1,1,1,1,0,0, 1,32'h00, 0,0));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h04, 0,0));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h08, 1,32'h00));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h0C, 1,32'h04));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h10, 1,32'h08));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h14, 1,32'h0C));
      vecs.push_back(mk(0,1,0,1,0,0, 1,32'h18, 1,32'h10));
      vecs.push_back(mk(0,1,0,1,0,0, 1,32'h1C, 1,32'h10));
      for (int k = 0; k < 8; k++) vecs.push_back(mk(0,1,0,1,0,0, 0,0, 1,32'h10));
      vecs.push_back(mk(0,1,1,1,0,0, 0,0,      1,32'h10));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h20, 1,32'h14));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h24, 1,32'h18));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h28, 1,32'h1C));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h2C, 1,32'h20));
      // Redirect to 0x100 with two requests in flight (2-cycle memory).
      vecs.push_back(mk(1,2,1,1,0,0,         1,32'h0,   0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h4,   0,0));
      vecs.push_back(mk(0,2,1,1,1,32'h100,   0,0,       0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         0,0,       0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h100, 0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h104, 0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         0,0,       0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h108, 1,32'h100));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h10C, 1,32'h104));
      // Redirect in the same cycle as a response and if_ready: one response left to drop.
      vecs.push_back(mk(1,2,0,1,0,0,         1,32'h0,   0,0));
      vecs.push_back(mk(0,2,0,1,0,0,         1,32'h4,   0,0));
      vecs.push_back(mk(0,2,0,1,0,0,         0,0,       0,0));
      vecs.push_back(mk(0,2,0,1,0,0,         1,32'h8,   1,32'h0));
      vecs.push_back(mk(0,2,0,1,0,0,         1,32'hC,   1,32'h0));
      vecs.push_back(mk(0,2,1,1,1,32'h200,   0,0,       1,32'h0));
      vecs.push_back(mk(0,2,1,1,0,0,         0,0,       0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h200, 0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h204, 0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         0,0,       0,0));
      vecs.push_back(mk(0,2,1,1,0,0,         1,32'h208, 1,32'h200));
      // Redirect near the top of the address space: request withdrawn, PC and link wrap.
      vecs.push_back(mk(1,1,1,1,1,32'hFFFF_FFF8, 0,0,            0,0));
      vecs.push_back(mk(0,1,1,1,0,0,             1,32'hFFFF_FFF8, 0,0));
      vecs.push_back(mk(0,1,1,1,0,0,             1,32'hFFFF_FFFC, 0,0));
      vecs.push_back(mk(0,1,1,1,0,0,             1,32'h0,  1,32'hFFFF_FFF8));
      vecs.push_back(mk(0,1,1,1,0,0,             1,32'h4,  1,32'hFFFF_FFFC));
      vecs.push_back(mk(0,1,1,1,0,0,             1,32'h8,  1,32'h0));
      // Memory not ready for 5 cycles: address held, issued once.
      vecs.push_back(mk(1,1,1,0,0,0, 1,32'h0, 0,0));
      for (int k = 0; k < 4; k++) vecs.push_back(mk(0,1,1,0,0,0, 1,32'h0, 0,0));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h0, 0,0));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h4, 0,0));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'h8, 1,32'h0));
      vecs.push_back(mk(0,1,1,1,0,0, 1,32'hC, 1,32'h4));

      #2;
      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset(vecs[i].lt);
         if_ready       = vecs[i].ifr;
         imem_req_ready = vecs[i].mr;
         redirect_valid = vecs[i].rd;
         redirect_pc    = vecs[i].rpc;
         @(negedge clock);
         chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].erv));
         if (vecs[i].erv)
            chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].ea);
         chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].eiv));
         if (vecs[i].eiv) begin
            chk($sformatf("v%0d_if_pc", i), if_pc, vecs[i].ep);
            chk($sformatf("v%0d_if_instr", i), if_instruction, word(vecs[i].ep));
            chk($sformatf("v%0d_if_pc_plus4", i), if_pc_plus4, vecs[i].ep + 32'd4);
         end else begin
            chk($sformatf("v%0d_if_nop", i), if_instruction, 32'h0000_0013);
         end
         @(posedge clock); #1;
      end
      redirect_valid = 1'b0;

      // Random stalls and redirects: decode must see a gap-free, in-order PC stream.
      for (int l = 1; l <= 2; l++) begin
         logic [31:0] exp_pc;
         int          pops;
         do_reset(l);
         exp_pc = 32'h0;
         pops   = 0;
         for (int c = 0; c < 300; c++) begin
            if_ready       = 1'($urandom_range(0, 1));
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = redirect_valid ? (32'($urandom_range(0, 1023)) << 2) : 32'h0;
            @(negedge clock);
            if (redirect_valid) begin
               exp_pc = redirect_pc;
            end else if (if_valid && if_ready) begin
               chk($sformatf("rand%0d_c%0d_pc", l, c), if_pc, exp_pc);
               chk($sformatf("rand%0d_c%0d_instr", l, c), if_instruction, word(exp_pc));
               exp_pc = exp_pc + 32'd4;
               pops++;
            end
            @(posedge clock); #1;
         end
         redirect_valid = 1'b0;
         chk($sformatf("rand%0d_enough_pops", l), 32'(pops >= 20), 32'd1);
      end

`ifdef IFETCH_MISALIGN_TRAP_EN
      begin
         bit seen;
         do_reset(1);
         repeat (3) begin @(posedge clock); #1; end
         redirect_valid = 1'b1;
         redirect_pc    = 32'h102;
         @(posedge clock); #1;
         redirect_valid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("mis%0d_req_valid", k), 32'(imem_req_valid), 32'd0);
            chk($sformatf("mis%0d_if_valid", k), 32'(if_valid), 32'd0);
            chk($sformatf("mis%0d_flag", k), 32'(if_misalign), 32'd1);
            chk($sformatf("mis%0d_if_pc", k), if_pc, 32'h102);
            @(posedge clock); #1;
         end
         redirect_valid = 1'b1;
         redirect_pc    = 32'h200;
         @(negedge clock);
         chk("mis_flag_before_exit", 32'(if_misalign), 32'd1);
         @(posedge clock); #1;
         redirect_valid = 1'b0;
         @(negedge clock);
         chk("mis_flag_cleared", 32'(if_misalign), 32'd0);
         chk("mis_resume_req_valid", 32'(imem_req_valid), 32'd1);
         chk("mis_resume_req_addr", imem_req_addr, 32'h200);
         @(posedge clock); #1;
         seen = 1'b0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (if_valid) begin
               seen = 1'b1;
               chk("mis_resume_if_pc", if_pc, 32'h200);
            end
            @(posedge clock); #1;
         end
         if (!seen) begin
            n_chk++;
            $display("FAIL mis_resume_timeout: if_valid never rose, required within 10 cycles");
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
